// File: rtl/wb_pkg.sv
// Shared types and defaults for the writeback arbiter slice.
package wb_pkg;
   localparam int WB_DEPTH_DEFAULT      = 4;
   localparam int WB_STARVE_MAX_DEFAULT = 3;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_entry_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus bundle: ALU/memory result inputs, issue scoreboard, register-file port, perf taps.
interface wb_arbiter_if;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        alu_stall;
   logic        mem_valid;
   logic        mem_ready;
   logic [4:0]  mem_rd;
   logic [31:0] mem_data;
   logic        iss_valid;
   logic [4:0]  iss_rd;
   logic [31:0] pending;
   logic        w_enabled;
   logic [4:0]  w_addr;
   logic [31:0] w_data;
   logic [31:0] perf_alu_wr;
   logic [31:0] perf_mem_wr;
   logic [31:0] perf_stall;

   modport slave (
      input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, iss_valid, iss_rd,
      output alu_stall, mem_ready, pending, w_enabled, w_addr, w_data,
             perf_alu_wr, perf_mem_wr, perf_stall
   );

   modport master (
      output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, iss_valid, iss_rd,
      input  alu_stall, mem_ready, pending, w_enabled, w_addr, w_data,
             perf_alu_wr, perf_mem_wr, perf_stall
   );
endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries; push while full and pop while empty are ignored.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = WB_DEPTH_DEFAULT
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  wb_entry_t                    push_data,
   input  logic                         pop,
   output wb_entry_t                    head,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   wb_entry_t       mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic            push_ok, pop_ok;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = mem[rd_ptr];

   // DEPTH is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU vs buffered memory results onto one register-file write port.
// Optional perf counters enabled by defining WB_PERF_EN.
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int DEPTH      = WB_DEPTH_DEFAULT,
   parameter int STARVE_MAX = WB_STARVE_MAX_DEFAULT
) (
   input logic        clk,
   input logic        rst,
   wb_arbiter_if.slave bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = $clog2(STARVE_MAX + 1);

   wb_entry_t       head, push_data;
   logic            full, empty, push, pop, alu_take, alu_stall;
   logic [CW-1:0]   count;
   logic [SW-1:0]   starve;
   logic [31:0]     pending, pend_next;
   logic            w_en_q;
   logic [4:0]      w_addr_q;
   logic [31:0]     w_data_q;

   assign alu_stall = (starve == SW'(STARVE_MAX));
   assign alu_take  = bus.alu_valid && !alu_stall;
   assign pop       = !alu_take && !empty;
   assign push      = bus.mem_valid && !full;
   assign push_data = '{rd: bus.mem_rd, data: bus.mem_data};

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk, .rst, .push, .push_data, .pop, .head, .full, .empty, .count
   );

   // A new issue to the same register beats the retiring pop.
   always_comb begin
      pend_next = pending;
      if (pop) pend_next[head.rd] = 1'b0;
      if (bus.iss_valid && bus.iss_rd != 5'd0) pend_next[bus.iss_rd] = 1'b1;
      pend_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_en_q   <= 1'b0;
         w_addr_q <= '0;
         w_data_q <= '0;
         starve   <= '0;
         pending  <= '0;
      end else begin
         if (alu_take) begin
            w_en_q <= (bus.alu_rd != 5'd0);
            if (bus.alu_rd != 5'd0) begin
               w_addr_q <= bus.alu_rd;
               w_data_q <= bus.alu_data;
            end
         end else if (pop) begin
            w_en_q <= (head.rd != 5'd0);
            if (head.rd != 5'd0) begin
               w_addr_q <= head.rd;
               w_data_q <= head.data;
            end
         end else begin
            w_en_q <= 1'b0;
         end
         if (pop || empty)  starve <= '0;
         else if (alu_take) starve <= starve + SW'(1);
         pending <= pend_next;
      end
   end

   assign bus.alu_stall = alu_stall;
   assign bus.mem_ready = !full;
   assign bus.pending   = pending;
   assign bus.w_enabled = w_en_q;
   assign bus.w_addr    = w_addr_q;
   assign bus.w_data    = w_data_q;

`ifdef WB_PERF_EN
   logic [31:0] perf_alu_q, perf_mem_q, perf_stall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_alu_q   <= '0;
         perf_mem_q   <= '0;
         perf_stall_q <= '0;
      end else begin
         if (alu_take && bus.alu_rd != 5'd0) perf_alu_q   <= perf_alu_q + 32'd1;
         if (pop && head.rd != 5'd0)         perf_mem_q   <= perf_mem_q + 32'd1;
         if (alu_stall && bus.alu_valid)     perf_stall_q <= perf_stall_q + 32'd1;
      end
   end

   assign bus.perf_alu_wr = perf_alu_q;
   assign bus.perf_mem_wr = perf_mem_q;
   assign bus.perf_stall  = perf_stall_q;
`else
   assign bus.perf_alu_wr = '0;
   assign bus.perf_mem_wr = '0;
   assign bus.perf_stall  = '0;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_wb_arbiter;
   import wb_pkg::*;

   localparam int DEPTH      = 4;
   localparam int STARVE_MAX = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   wb_arbiter_if bus();

   wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   // reference model state
   wb_entry_t   mq[$];
   int          m_starve;
   logic [31:0] m_pend;
   logic        m_en;
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   int          m_palu, m_pmem, m_pstall;
   logic        m_pre_stall, m_pre_ready;
   logic        s_stall, s_ready;

   // advance one clock: sample pre-edge combinational outputs, update the model, clock the DUT
   task automatic cycle();
      bit stall_m, alu_ok, pop_m;
      wb_entry_t h;
      #2;
      s_stall = bus.alu_stall;
      s_ready = bus.mem_ready;
      m_pre_stall = (m_starve == STARVE_MAX);
      m_pre_ready = (mq.size() < DEPTH);
      if (rst) begin
         mq.delete();
         m_starve = 0; m_pend = '0; m_en = 0; m_addr = '0; m_data = '0;
         m_palu = 0; m_pmem = 0; m_pstall = 0;
      end else begin
         stall_m = m_pre_stall;
         alu_ok  = bus.alu_valid && !stall_m;
         pop_m   = !alu_ok && mq.size() > 0;
         if (stall_m && bus.alu_valid) m_pstall++;
         if (alu_ok) begin
            m_en = (bus.alu_rd != 0);
            if (m_en) begin m_addr = bus.alu_rd; m_data = bus.alu_data; m_palu++; end
         end else if (pop_m) begin
            h = mq.pop_front();
            m_en = (h.rd != 0);
            if (m_en) begin m_addr = h.rd; m_data = h.data; m_pmem++; end
            m_pend[h.rd] = 1'b0;
         end else begin
            m_en = 0;
         end
         if (pop_m || (mq.size() == 0 && !pop_m)) m_starve = 0;
         else if (alu_ok) m_starve++;
         if (bus.iss_valid && bus.iss_rd != 0) m_pend[bus.iss_rd] = 1'b1;
         m_pend[0] = 1'b0;
         if (bus.mem_valid && m_pre_ready) mq.push_back('{rd: bus.mem_rd, data: bus.mem_data});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.alu_valid = 0; bus.alu_rd = '0; bus.alu_data = '0;
      bus.mem_valid = 0; bus.mem_rd = '0; bus.mem_data = '0;
      bus.iss_valid = 0; bus.iss_rd = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1; cycle(); rst = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      bus.alu_valid = 1; bus.alu_rd = 5'd4; bus.alu_data = 32'hFFFF_0000;
      cycle();
      rst = 1; idle_inputs(); cycle(); rst = 0;
      checks++; if (bus.w_enabled !== 1'b0) begin errors++; $display("FAIL reset_w_en got %b exp 0", bus.w_enabled); end
      checks++; if (bus.w_addr !== 5'd0 || bus.w_data !== 32'd0) begin errors++; $display("FAIL reset_w_bus got %0d/%h exp 0/0", bus.w_addr, bus.w_data); end
      checks++; if (bus.pending !== 32'd0) begin errors++; $display("FAIL reset_pending got %h exp 0", bus.pending); end
      checks++; if (bus.alu_stall !== 1'b0 || bus.mem_ready !== 1'b1) begin errors++; $display("FAIL reset_hs got stall=%b ready=%b exp 0/1", bus.alu_stall, bus.mem_ready); end
      checks++; if ((bus.perf_alu_wr | bus.perf_mem_wr | bus.perf_stall) !== 32'd0) begin errors++; $display("FAIL reset_perf got %0d/%0d/%0d exp 0", bus.perf_alu_wr, bus.perf_mem_wr, bus.perf_stall); end
   endtask

   task automatic test_alu_only();
      do_reset();
      bus.alu_valid = 1; bus.alu_rd = 5'd5; bus.alu_data = 32'h1234;
      cycle();
      idle_inputs();
      checks++; if (bus.w_enabled !== 1'b1 || bus.w_addr !== 5'd5 || bus.w_data !== 32'h1234) begin errors++; $display("FAIL alu_write got %b/%0d/%h exp 1/5/1234", bus.w_enabled, bus.w_addr, bus.w_data); end
      cycle();
      checks++; if (bus.w_enabled !== 1'b0 || bus.w_addr !== 5'd5) begin errors++; $display("FAIL alu_one_shot got en=%b addr=%0d exp 0/5", bus.w_enabled, bus.w_addr); end
   endtask

   task automatic test_mem_only();
      do_reset();
      bus.iss_valid = 1; bus.iss_rd = 5'd7;
      cycle();
      idle_inputs();
      checks++; if (bus.pending[7] !== 1'b1) begin errors++; $display("FAIL pend_set got %b exp 1", bus.pending[7]); end
      cycle();
      bus.mem_valid = 1; bus.mem_rd = 5'd7; bus.mem_data = 32'hDEAD;
      cycle();
      idle_inputs();
      checks++; if (bus.pending[7] !== 1'b1 || bus.w_enabled !== 1'b0) begin errors++; $display("FAIL pend_hold got pend=%b en=%b exp 1/0", bus.pending[7], bus.w_enabled); end
      cycle();
      checks++; if (bus.w_enabled !== 1'b1 || bus.w_addr !== 5'd7 || bus.w_data !== 32'hDEAD) begin errors++; $display("FAIL mem_write got %b/%0d/%h exp 1/7/dead", bus.w_enabled, bus.w_addr, bus.w_data); end
      checks++; if (bus.pending[7] !== 1'b0) begin errors++; $display("FAIL pend_clear got %b exp 0", bus.pending[7]); end
   endtask

   task automatic test_fifo_full();
      int pushed = 0;
      int seen = 0;
      bit saw_full = 0;
      do_reset();
      for (int i = 0; i < 60 && seen < 5; i++) begin
         bus.alu_valid = (pushed < 5); bus.alu_rd = 5'd1; bus.alu_data = 32'h1000_0000 + i;
         bus.mem_valid = (pushed < 5); bus.mem_rd = 5'(8 + pushed); bus.mem_data = 32'hA000_0000 + pushed;
         cycle();
         if (bus.mem_valid && s_ready) pushed++;
         if (pushed == 4 && !saw_full) begin
            saw_full = 1;
            checks++; if (bus.mem_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", bus.mem_ready); end
         end
         if (bus.w_enabled && bus.w_data[31:28] == 4'hA) begin
            checks++;
            if (bus.w_data !== 32'hA000_0000 + seen || bus.w_addr !== 5'(8 + seen)) begin
               errors++; $display("FAIL full_order got %0d/%h exp %0d/%h", bus.w_addr, bus.w_data, 8 + seen, 32'hA000_0000 + seen);
            end
            seen++;
         end
      end
      idle_inputs();
      checks++; if (seen != 5) begin errors++; $display("FAIL full_drain got %0d entries exp 5", seen); end
   endtask

   task automatic test_starvation();
      do_reset();
      bus.alu_valid = 1; bus.alu_rd = 5'd3; bus.alu_data = 32'h3333_3333;
      bus.mem_valid = 1; bus.mem_rd = 5'd9; bus.mem_data = 32'hBEEF;
      cycle();
      bus.mem_valid = 0;
      for (int k = 0; k < 3; k++) begin
         cycle();
         checks++; if (bus.alu_stall !== (k == 2)) begin errors++; $display("FAIL starve_stall k=%0d got %b exp %b", k, bus.alu_stall, k == 2); end
      end
      cycle();
      checks++; if (bus.w_enabled !== 1'b1 || bus.w_addr !== 5'd9 || bus.w_data !== 32'hBEEF || bus.alu_stall !== 1'b0) begin errors++; $display("FAIL starve_pop got %b/%0d/%h stall=%b exp 1/9/beef/0", bus.w_enabled, bus.w_addr, bus.w_data, bus.alu_stall); end
      cycle();
      idle_inputs();
      checks++; if (bus.w_enabled !== 1'b1 || bus.w_addr !== 5'd3 || bus.w_data !== 32'h3333_3333) begin errors++; $display("FAIL starve_alu got %b/%0d/%h exp 1/3/33333333", bus.w_enabled, bus.w_addr, bus.w_data); end
   endtask

   task automatic test_x0_reset();
      int stray = 0;
      do_reset();
      bus.alu_valid = 1; bus.alu_rd = 5'd0; bus.alu_data = 32'h55;
      cycle();
      checks++; if (bus.w_enabled !== 1'b0) begin errors++; $display("FAIL x0_write got %b exp 0", bus.w_enabled); end
      bus.alu_rd = 5'd2;
      bus.iss_valid = 1; bus.iss_rd = 5'd12;
      for (int k = 0; k < 3; k++) begin
         bus.mem_valid = 1; bus.mem_rd = 5'(12 + k); bus.mem_data = 32'hC0 + k;
         cycle();
         bus.iss_valid = 0;
      end
      idle_inputs();
      rst = 1; cycle(); rst = 0;
      checks++; if (bus.w_enabled !== 1'b0 || bus.w_addr !== 5'd0 || bus.w_data !== 32'd0 || bus.pending !== 32'd0) begin errors++; $display("FAIL midreset got %b/%0d/%h pend=%h exp zeros", bus.w_enabled, bus.w_addr, bus.w_data, bus.pending); end
      checks++; if (bus.mem_ready !== 1'b1 || bus.alu_stall !== 1'b0) begin errors++; $display("FAIL midreset_hs got ready=%b stall=%b exp 1/0", bus.mem_ready, bus.alu_stall); end
      for (int k = 0; k < 6; k++) begin
         cycle();
         if (bus.w_enabled !== 1'b0) stray++;
      end
      checks++; if (stray != 0) begin errors++; $display("FAIL midreset_drop got %0d writes exp 0", stray); end
   endtask

   task automatic test_perf();
      int ea, em, es;
`ifdef WB_PERF_EN
      ea = 3; em = 2; es = 1;
`else
      ea = 0; em = 0; es = 0;
`endif
      do_reset();
      bus.mem_valid = 1; bus.mem_rd = 5'd20; bus.mem_data = 32'h1;
      cycle();
      bus.alu_valid = 1; bus.alu_rd = 5'd6; bus.alu_data = 32'h66;
      bus.mem_rd = 5'd21; bus.mem_data = 32'h2;
      cycle();
      bus.mem_valid = 0;
      cycle(); cycle();
      cycle();
      idle_inputs();
      cycle(); cycle();
      checks++; if (bus.perf_alu_wr !== 32'(ea) || bus.perf_mem_wr !== 32'(em) || bus.perf_stall !== 32'(es)) begin errors++; $display("FAIL perf_counts got %0d/%0d/%0d exp %0d/%0d/%0d", bus.perf_alu_wr, bus.perf_mem_wr, bus.perf_stall, ea, em, es); end
   endtask

   task automatic test_random();
      int bad = 0;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         bus.alu_valid = ($urandom_range(0, 9) < 7);
         bus.alu_rd    = 5'($urandom_range(0, 31));
         bus.alu_data  = $urandom;
         bus.mem_valid = ($urandom_range(0, 1) == 1);
         bus.mem_rd    = 5'($urandom_range(0, 31));
         bus.mem_data  = $urandom;
         bus.iss_valid = ($urandom_range(0, 9) < 3);
         bus.iss_rd    = 5'($urandom_range(0, 31));
         cycle();
         checks++;
         if (s_stall !== m_pre_stall || s_ready !== m_pre_ready || bus.w_enabled !== m_en ||
             (m_en && (bus.w_addr !== m_addr || bus.w_data !== m_data)) || bus.pending !== m_pend) begin
            errors++;
            if (bad++ < 8)
               $display("FAIL rand_cycle %0d got st=%b rdy=%b en=%b a=%0d d=%h p=%h exp st=%b rdy=%b en=%b a=%0d d=%h p=%h",
                        i, s_stall, s_ready, bus.w_enabled, bus.w_addr, bus.w_data, bus.pending,
                        m_pre_stall, m_pre_ready, m_en, m_addr, m_data, m_pend);
         end
      end
      idle_inputs();
`ifdef WB_PERF_EN
      checks++; if (bus.perf_alu_wr !== 32'(m_palu) || bus.perf_mem_wr !== 32'(m_pmem) || bus.perf_stall !== 32'(m_pstall)) begin errors++; $display("FAIL rand_perf got %0d/%0d/%0d exp %0d/%0d/%0d", bus.perf_alu_wr, bus.perf_mem_wr, bus.perf_stall, m_palu, m_pmem, m_pstall); end
`else
      checks++; if ((bus.perf_alu_wr | bus.perf_mem_wr | bus.perf_stall) !== 32'd0) begin errors++; $display("FAIL rand_perf got %0d/%0d/%0d exp 0", bus.perf_alu_wr, bus.perf_mem_wr, bus.perf_stall); end
`endif
   endtask

   initial begin
      idle_inputs();
      mq.delete();
      m_starve = 0; m_pend = '0; m_en = 0; m_addr = '0; m_data = '0;
      m_palu = 0; m_pmem = 0; m_pstall = 0;
      test_reset();
      test_alu_only();
      test_mem_only();
      test_fifo_full();
      test_starvation();
      test_x0_reset();
      test_perf();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Writeback stage directly upstream of the register file. It merges single-cycle ALU results and variable-latency memory/load results into the file's single write port (w_enabled/w_addr/w_data). Memory results are buffered in a small FIFO. The block also keeps a pending-destination scoreboard that the decode stage reads to stall on outstanding long-latency writes.

Parameters:
DEPTH, 4, memory-result FIFO entries (power of two, >=2)
STARVE_MAX, 3, consecutive cycles a non-empty FIFO may lose arbitration before the ALU is stalled

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
alu_valid  in  1  ALU result valid this cycle
alu_rd  in  5  ALU destination register
alu_data  in  32  ALU result
alu_stall  out  1  ALU result not accepted this cycle; upstream holds it
mem_valid  in  1  memory result offered
mem_ready  out  1  FIFO can accept
mem_rd  in  5  memory destination register
mem_data  in  32  memory result
iss_valid  in  1  long-latency op issued this cycle
iss_rd  in  5  its destination register
pending  out  32  bit i = write to x[i] still outstanding
w_enabled  out  1  register-file write enable
w_addr  out  5  register-file write address
w_data  out  32  register-file write data
perf_alu_wr, perf_mem_wr, perf_stall  out  32 each  performance counters (see Optional Feature)

Behaviour:
- Reset, synchronous, active-high:
  - w_enabled=0, w_addr=0, w_data=0, pending=0, alu_stall=0, mem_ready=1
  - FIFO emptied, starve counter=0, perf counters=0
  - Reset mid-operation discards all queued entries; writes in flight are lost.
- Write outputs are registered. A result selected in cycle N appears on w_* in cycle N+1 for exactly one cycle.
- Arbitration each cycle:
  - alu_stall=0 and alu_valid=1 -> ALU wins, FIFO head waits.
  - Otherwise, FIFO non-empty -> head popped and emitted.
  - Neither -> w_enabled=0 next cycle; w_addr/w_data hold their last value.
- Starvation guard:
  - Counter increments each cycle the FIFO is non-empty and loses to the ALU.
  - Counter clears when FIFO pops or FIFO is empty.
  - alu_stall = (counter == STARVE_MAX). It is combinational from the counter register.
  - While alu_stall=1 the FIFO pops regardless of alu_valid, and the ALU input is ignored.
- rd==0: the entry is consumed (ALU accepted or FIFO popped) but w_enabled stays 0. x0 is never written.
- FIFO handshake:
  - Push when mem_valid && mem_ready.
  - mem_ready = (count != DEPTH), derived from count only. A push while full is not accepted even if a pop happens the same cycle.
  - Push and pop in the same cycle when non-empty and not full: count unchanged.
  - Pointers wrap modulo DEPTH.
- Scoreboard:
  - iss_valid && iss_rd!=0 sets pending[iss_rd].
  - A FIFO pop for rd clears pending[rd].
  - Set and clear of the same bit in the same cycle: set wins.
  - ALU writes never touch pending.
  - Upstream guarantees at most one outstanding long op per rd.
  - pending[0] is always 0.

Optional Feature:
WB_PERF_EN
- Defined:
  - perf_alu_wr increments on each emitted ALU write with rd!=0.
  - perf_mem_wr increments on each emitted FIFO write with rd!=0.
  - perf_stall increments each cycle alu_stall && alu_valid.
  - All counters wrap at 2^32 and clear on rst.
- Undefined: the counter logic is absent and the three ports are tied to 0.

Decomposition:
- Package wb_pkg holds:
  - wb_entry_t packed struct {rd[4:0], data[31:0]}
  - WB_DEPTH_DEFAULT=4
  - WB_STARVE_MAX_DEFAULT=3
- One sub-module, wb_fifo: parameterised synchronous FIFO of wb_entry_t with push/pop/full/empty/count; reset per rst.

Test Plan:
- ALU only: alu_valid, rd=5, data=0x1234 at cycle N -> w_enabled=1, w_addr=5, w_data=0x1234 at N+1; w_enabled=0 at N+2.
- Mem only: push rd=7 data=0xDEAD with iss rd=7 set two cycles earlier -> pending[7]=1 until the pop; w_* write at pop+1; pending[7]=0 after.
- FIFO full: DEPTH+1 pushes while ALU continuously valid -> mem_ready=0 after 4 pushes; the 5th is held; no entry is lost or reordered.
- Starvation: FIFO holds 1 entry, alu_valid stuck 1 -> alu_stall=1 on the 4th cycle; FIFO entry written; alu_stall=0 the next cycle; the held ALU result is then written.
- x0 and reset: ALU rd=0 -> w_enabled stays 0. Assert rst with 3 queued entries -> all outputs zero next cycle, mem_ready=1, no further writes.
- WB_PERF_EN: 3 ALU writes, 2 mem writes, 1 stalled cycle -> counters read 3/2/1. Without the macro all three counters read 0.
